// File: rtl/mux4to1_rr_arb.sv
// Four-channel valid/ready merge into one registered output.
// Each beat is tagged with its source channel. Arbitration is round-robin or fixed priority.
module mux4to1_rr_arb #(
  parameter int DW       = 8,
  parameter bit ARB_MODE = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [3:0]      IN_VALID,
  input  logic [4*DW-1:0] IN_DATA,
  output logic [3:0]      IN_READY,
  output logic            OUT_VALID,
  output logic [DW-1:0]   OUT_DATA,
  output logic [1:0]      OUT_SEL,
  input  logic            OUT_READY
);

  logic [1:0]    ptr;
  logic [1:0]    base;
  logic [1:0]    grant;
  logic [1:0]    idx;
  logic          gnt_any;
  logic          can_load;
  logic          load;
  logic [DW-1:0] gnt_data;

  // Fixed priority is round-robin with the search always starting at channel 0.
  assign base = ARB_MODE ? ptr : 2'd0;

  // Walk the offsets from farthest to nearest so the nearest requester is left in grant.
  always_comb begin
    grant = base;
    idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (IN_VALID[idx]) grant = idx;
    end
  end

  always_comb begin
    gnt_data = IN_DATA[0 +: DW];
    case (grant)
      2'd0:    gnt_data = IN_DATA[0*DW +: DW];
      2'd1:    gnt_data = IN_DATA[1*DW +: DW];
      2'd2:    gnt_data = IN_DATA[2*DW +: DW];
      default: gnt_data = IN_DATA[3*DW +: DW];
    endcase
  end

  assign gnt_any  = |IN_VALID;
  assign can_load = !OUT_VALID || OUT_READY;
  assign load     = can_load && gnt_any;

  // IN_READY is gated by RST_N so no channel sees a handshake while reset is held.
  assign IN_READY = (RST_N && load) ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_SEL   <= 2'd0;
      ptr       <= 2'd0;
    end else if (can_load) begin
      OUT_VALID <= gnt_any;
      if (gnt_any) begin
        OUT_DATA <= gnt_data;
        OUT_SEL  <= grant;
        if (ARB_MODE) ptr <= grant + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mux4to1_rr_arb.sv
// Scoreboard bench for mux4to1_rr_arb: a round-robin and a fixed-priority instance share stimulus.
// Expected beats are queued at issue time and popped by monitors on each output transfer.
module tb_mux4to1_rr_arb;
  localparam int DW = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [3:0]      IN_VALID = 4'b0000;
  logic [4*DW-1:0] IN_DATA;
  logic            OUT_READY = 1'b0;

  logic [3:0]    rdy_rr, rdy_fp;
  logic          ov_rr, ov_fp;
  logic [DW-1:0] od_rr, od_fp;
  logic [1:0]    os_rr, os_fp;

  int total = 0;
  int bad = 0;
  bit chk_rr = 1'b1;
  bit chk_fp = 1'b0;
  logic [9:0] q_rr[$];
  logic [9:0] q_fp[$];

  always #5 CLK = ~CLK;

  mux4to1_rr_arb #(.DW(DW), .ARB_MODE(1'b1)) dut_rr (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(rdy_rr), .OUT_VALID(ov_rr), .OUT_DATA(od_rr), .OUT_SEL(os_rr),
    .OUT_READY(OUT_READY)
  );

  mux4to1_rr_arb #(.DW(DW), .ARB_MODE(1'b0)) dut_fp (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .IN_READY(rdy_fp), .OUT_VALID(ov_fp), .OUT_DATA(od_fp), .OUT_SEL(os_fp),
    .OUT_READY(OUT_READY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dat(input int i);
    return 8'hA0 + 8'(i);
  endfunction

  // Monitors sample just before each rising edge, when the transfer condition is settled.
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge CLK);
      #4;
      if (RST_N && chk_rr && ov_rr && OUT_READY) begin
        if (q_rr.size() == 0) chk("rr_unexpected_beat", 32'(os_rr), 32'hFF);
        else begin
          exp = q_rr.pop_front();
          chk("rr_beat_sel", 32'(os_rr), 32'(exp[9:8]));
          chk("rr_beat_data", 32'(od_rr), 32'(exp[7:0]));
        end
      end
      if (RST_N && chk_fp && ov_fp && OUT_READY) begin
        if (q_fp.size() == 0) chk("fp_unexpected_beat", 32'(os_fp), 32'hFF);
        else begin
          exp = q_fp.pop_front();
          chk("fp_beat_sel", 32'(os_fp), 32'(exp[9:8]));
          chk("fp_beat_data", 32'(od_fp), 32'(exp[7:0]));
        end
      end
    end
  end

  initial begin
    IN_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset with every channel requesting
    @(negedge CLK);
    RST_N = 1'b0; IN_VALID = 4'b1111; OUT_READY = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      #1;
      chk("rst_ready", 32'(rdy_rr), 32'h0);
      chk("rst_valid", 32'(ov_rr), 32'h0);
      chk("rst_data", 32'(od_rr), 32'h0);
      chk("rst_sel", 32'(os_rr), 32'h0);
    end

    // Release and round-robin through all four channels
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready", 32'(rdy_rr), 32'(1) << (i % 4));
      q_rr.push_back({2'(i % 4), dat(i % 4)});
      if (i > 0) begin
        chk("rr_valid_cont", 32'(ov_rr), 32'h1);
        chk("rr_sel_now", 32'(os_rr), 32'((i - 1) % 4));
      end
      @(negedge CLK);
    end
    IN_VALID = 4'b0000;
    #1;
    chk("rr_last_sel", 32'(os_rr), 32'h1);
    @(negedge CLK);
    #1;
    chk("rr_drained", 32'(ov_rr), 32'h0);

    // Pointer wrap: channel 3 alone, then channels 0 and 1
    @(negedge CLK);
    IN_VALID = 4'b1000;
    #1;
    chk("wrap_ready3", 32'(rdy_rr), 32'h8);
    q_rr.push_back({2'd3, 8'hA3});
    @(negedge CLK);
    IN_VALID = 4'b0011;
    #1;
    chk("wrap_ready0", 32'(rdy_rr), 32'h1);
    chk("wrap_sel3", 32'(os_rr), 32'h3);
    q_rr.push_back({2'd0, 8'hA0});
    @(negedge CLK);
    #1;
    chk("wrap_ready1", 32'(rdy_rr), 32'h2);
    q_rr.push_back({2'd1, 8'hA1});
    @(negedge CLK);
    IN_VALID = 4'b0000;
    @(negedge CLK);
    #1;
    chk("wrap_drained", 32'(ov_rr), 32'h0);

    // Backpressure while holding channel 2's beat
    @(negedge CLK);
    IN_VALID = 4'b0100;
    #1;
    chk("bp_ready2", 32'(rdy_rr), 32'h4);
    q_rr.push_back({2'd2, 8'hA2});
    @(negedge CLK);
    OUT_READY = 1'b0; IN_VALID = 4'b1111;
    repeat (4) begin
      #1;
      chk("bp_ready_off", 32'(rdy_rr), 32'h0);
      chk("bp_hold_valid", 32'(ov_rr), 32'h1);
      chk("bp_hold_sel", 32'(os_rr), 32'h2);
      chk("bp_hold_data", 32'(od_rr), 32'hA2);
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    #1;
    chk("bp_ready3", 32'(rdy_rr), 32'h8);
    q_rr.push_back({2'd3, 8'hA3});
    @(negedge CLK);
    IN_VALID = 4'b0000;
    #1;
    chk("bp_nobubble_valid", 32'(ov_rr), 32'h1);
    chk("bp_nobubble_sel", 32'(os_rr), 32'h3);
    chk("bp_nobubble_data", 32'(od_rr), 32'hA3);
    @(negedge CLK);
    #1;
    chk("bp_drained", 32'(ov_rr), 32'h0);

    // Idle drain of a single channel-1 beat
    @(negedge CLK);
    IN_VALID = 4'b0010;
    #1;
    chk("idle_ready1", 32'(rdy_rr), 32'h2);
    q_rr.push_back({2'd1, 8'hA1});
    @(negedge CLK);
    IN_VALID = 4'b0000;
    #1;
    chk("idle_valid_hi", 32'(ov_rr), 32'h1);
    @(negedge CLK);
    #1;
    chk("idle_valid_lo", 32'(ov_rr), 32'h0);
    chk("idle_keep_data", 32'(od_rr), 32'hA1);
    chk("idle_keep_sel", 32'(os_rr), 32'h1);
    @(negedge CLK);
    #1;
    chk("idle_still_lo", 32'(ov_rr), 32'h0);
    chk("rr_queue_left", 32'(q_rr.size()), 32'h0);

    // Fixed priority: channel 1 always beats channels 2 and 3
    @(negedge CLK);
    chk_rr = 1'b0;
    RST_N = 1'b0; IN_VALID = 4'b0000;
    @(negedge CLK);
    RST_N = 1'b1; chk_fp = 1'b1; IN_VALID = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fp_ready1", 32'(rdy_fp), 32'h2);
      q_fp.push_back({2'd1, 8'hA1});
      if (i > 0) chk("fp_sel_now", 32'(os_fp), 32'h1);
      @(negedge CLK);
    end
    IN_VALID = 4'b0000;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("fp_drained", 32'(ov_fp), 32'h0);
    chk("fp_queue_left", 32'(q_fp.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
